// File: rtl/ceespu_pc_ras.sv
`default_nettype none
// ============================================================================
// Module   : ceespu_pc_ras
// Purpose  : Program counter for the ceespu fetch stage. It supports a
//            configurable width, reset vector and sequential step, and it
//            redirects call/return through a circular hardware
//            return-address stack (RAS).
//            Optional feature macro: CEESPU_PC_IRQ_EN. When this macro is
//            defined, the block adds interrupt entry/exit with a saved
//            exception PC.
// Ports    : I_clk            rising-edge clock
//            I_rst_n          asynchronous active-low reset
//            I_stall          hold the PC when no redirect is present
//            I_branch         jump to I_branchAddress
//            I_call           push O_PC+STEP, then jump to I_branchAddress
//            I_ret            pop the RAS into the PC
//            I_branchAddress  branch/call target
//            I_irq            level interrupt request (IRQ build only)
//            I_reti           return from interrupt (IRQ build only)
//            O_PC             current fetch address
//            O_ras_count      number of valid RAS entries
//            O_ras_overflow   sticky: a push happened while the RAS was full
//            O_ras_underflow  sticky: a pop happened while the RAS was empty
//            O_in_irq         interrupt handler active (0 without IRQ build)
//            O_epc            saved exception PC (0 without IRQ build)
// Revision : 1.0 - initial release
// ============================================================================
module ceespu_pc_ras #(
  parameter int                ADDR_W       = 14,
  parameter int                STEP         = 1,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(4)
) (
  input  logic                           I_clk,
  input  logic                           I_rst_n,
  input  logic                           I_stall,
  input  logic                           I_branch,
  input  logic                           I_call,
  input  logic                           I_ret,
  input  logic [ADDR_W-1:0]              I_branchAddress,
  input  logic                           I_irq,
  input  logic                           I_reti,
  output logic [ADDR_W-1:0]              O_PC,
  output logic [$clog2(RAS_DEPTH+1)-1:0] O_ras_count,
  output logic                           O_ras_overflow,
  output logic                           O_ras_underflow,
  output logic                           O_in_irq,
  output logic [ADDR_W-1:0]              O_epc
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [ADDR_W-1:0] c_step     = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  c_full     = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  c_last_ptr = PTR_W'(RAS_DEPTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;    // index of the most recently pushed entry
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  // --------------------------------------------------------------------------
  // Interrupt qualification. In the non-IRQ build these are constant zero,
  // so the priority chain below is identical in both builds.
  // --------------------------------------------------------------------------
  logic              w_irq_take;
  logic              w_reti_req;
  logic              w_in_irq;
  logic [ADDR_W-1:0] w_epc;

`ifdef CEESPU_PC_IRQ_EN
  logic              r_in_irq;
  logic [ADDR_W-1:0] r_epc;

  // An interrupt is taken only on a quiet, unstalled cycle. A blocked
  // request stays pending because I_irq is a level signal.
  assign w_irq_take = I_irq && !r_in_irq && !I_stall &&
                      !(I_branch || I_call || I_ret || I_reti);
  assign w_reti_req = I_reti;
  assign w_in_irq   = r_in_irq;
  assign w_epc      = r_epc;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_in_irq <= 1'b0;
      r_epc    <= '0;
    end else if (w_irq_take) begin
      r_in_irq <= 1'b1;
      r_epc    <= r_pc;
    end else if (I_reti && r_in_irq) begin
      r_in_irq <= 1'b0;
    end
  end
`else
  // The interrupt inputs and the vector have no function in this build.
  logic w_unused_irq;
  assign w_unused_irq = ^{I_irq, I_reti, IRQ_VECTOR};

  assign w_irq_take = 1'b0;
  assign w_reti_req = 1'b0;
  assign w_in_irq   = 1'b0;
  assign w_epc      = '0;
`endif

  // --------------------------------------------------------------------------
  // Next-PC selection and RAS control
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_push;
  logic              w_pop;
  logic              w_underflow_set;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic [PTR_W-1:0]  w_top_inc;
  logic [PTR_W-1:0]  w_top_dec;

  assign w_pc_seq    = r_pc + c_step;   // truncation gives a silent wrap
  assign w_ras_empty = (r_count == '0);
  assign w_ras_full  = (r_count == c_full);

  // Explicit modulo arithmetic allows RAS_DEPTH values that are not powers of two.
  assign w_top_inc = (r_top == c_last_ptr) ? '0 : r_top + PTR_W'(1);
  assign w_top_dec = (r_top == '0) ? c_last_ptr : r_top - PTR_W'(1);

  always_comb begin
    w_pc_next       = r_pc;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_underflow_set = 1'b0;

    if (w_irq_take) begin
      w_pc_next = IRQ_VECTOR;
    end else if (w_reti_req) begin
      // A stray reti outside a handler advances the PC, even when stalled.
      w_pc_next = w_in_irq ? w_epc : w_pc_seq;
    end else if (I_branch) begin
      w_pc_next = I_branchAddress;
    end else if (I_call) begin
      w_pc_next = I_branchAddress;
      w_push    = 1'b1;
    end else if (I_ret) begin
      if (!w_ras_empty) begin
        w_pc_next = r_ras[r_top];
        w_pop     = 1'b1;
      end else begin
        w_pc_next       = w_pc_seq;
        w_underflow_set = 1'b1;
      end
    end else if (!I_stall) begin
      w_pc_next = w_pc_seq;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // When the stack is full, the slot after the top holds the oldest entry.
  // A push therefore overwrites the oldest entry without special handling.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_top       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_top <= w_top_inc;
        if (w_ras_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (w_pop) begin
        r_top   <= w_top_dec;
        r_count <= r_count - CNT_W'(1);
      end
      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Stack storage has no reset. Reset clears the count, so stale entries
  // become unreachable.
  always_ff @(posedge I_clk) begin
    if (w_push) begin
      r_ras[w_top_inc] <= w_pc_seq;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign O_PC            = r_pc;
  assign O_ras_count     = r_count;
  assign O_ras_overflow  = r_overflow;
  assign O_ras_underflow = r_underflow;
  assign O_in_irq        = w_in_irq;
  assign O_epc           = w_epc;

endmodule
`default_nettype wire

// File: tb/tb_ceespu_pc_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_ceespu_pc_ras
// Purpose  : Testbench for ceespu_pc_ras. It runs directed scenarios and then
//            randomized traffic. The randomized traffic is checked against a
//            queue-based reference model. A second instance with ADDR_W=8 and
//            STEP=4 covers the wrap boundary.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ceespu_pc_ras;

  localparam int STEP = 1;
  localparam int DEPTH = 4;
`ifdef CEESPU_PC_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
  logic        irq = 1'b0, reti = 1'b0;
  logic [13:0] baddr = '0;
  logic [13:0] pc, epc;
  logic [2:0]  cnt;
  logic        ovf, unf, in_irq;

  logic        z0 = 1'b0;
  logic [7:0]  zaddr = '0;
  logic [7:0]  pc2, epc2;
  logic [2:0]  cnt2;
  logic        ovf2, unf2, in_irq2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ceespu_pc_ras dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_stall(stall), .I_branch(branch),
    .I_call(call), .I_ret(ret), .I_branchAddress(baddr), .I_irq(irq),
    .I_reti(reti), .O_PC(pc), .O_ras_count(cnt), .O_ras_overflow(ovf),
    .O_ras_underflow(unf), .O_in_irq(in_irq), .O_epc(epc)
  );

  ceespu_pc_ras #(.ADDR_W(8), .STEP(4), .RESET_VECTOR(8'hF0), .RAS_DEPTH(4),
                  .IRQ_VECTOR(8'h04)) dut2 (
    .I_clk(clk), .I_rst_n(rst_n), .I_stall(z0), .I_branch(z0),
    .I_call(z0), .I_ret(z0), .I_branchAddress(zaddr), .I_irq(z0),
    .I_reti(z0), .O_PC(pc2), .O_ras_count(cnt2), .O_ras_overflow(ovf2),
    .O_ras_underflow(unf2), .O_in_irq(in_irq2), .O_epc(epc2)
  );

  // Reference model
  logic [13:0] m_pc, m_epc;
  logic [13:0] m_q[$];
  bit          m_ovf, m_unf, m_in;

  task automatic model_reset();
    m_pc = 14'h0; m_epc = 14'h0; m_q.delete();
    m_ovf = 0; m_unf = 0; m_in = 0;
  endtask

  task automatic model_apply();
    logic [13:0] seq;
    seq = m_pc + 14'(STEP);
    if (IRQ_BUILD && irq && !m_in && !stall && !(branch || call || ret || reti)) begin
      m_epc = m_pc; m_pc = 14'h0004; m_in = 1;
    end else if (IRQ_BUILD && reti) begin
      if (m_in) begin m_pc = m_epc; m_in = 0; end
      else m_pc = seq;
    end else if (branch) begin
      m_pc = baddr;
    end else if (call) begin
      m_q.push_back(seq);
      if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_ovf = 1; end
      m_pc = baddr;
    end else if (ret) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = seq; m_unf = 1; end
    end else if (!stall) begin
      m_pc = seq;
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; call = 0; ret = 0; irq = 0; reti = 0; baddr = '0;
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 14'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ovf, unf); end
    checks++; if (in_irq !== 1'b0 || epc !== 14'h0) begin failures++; $display("FAIL reset_irq got=%b/%0h exp=0/0", in_irq, epc); end
    checks++; if (pc2 !== 8'hF0) begin failures++; $display("FAIL reset_vector2 got=%0h exp=f0", pc2); end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (pc !== 14'(i)) begin failures++; $display("FAIL seq_pc got=%0h exp=%0h", pc, i); end
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 14'h5) begin failures++; $display("FAIL stall_hold got=%0h exp=5", pc); end
    end
    stall = 0;
    #3 rst_n = 0;
    #1;
    checks++; if (pc !== 14'h0) begin failures++; $display("FAIL async_reset_pc got=%0h exp=0", pc); end
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_call_ret();
    do_reset();
    branch = 1; baddr = 14'd10; step(); idle();
    checks++; if (pc !== 14'd10) begin failures++; $display("FAIL branch_pc got=%0h exp=a", pc); end
    call = 1; baddr = 14'h100; step(); idle();
    checks++; if (pc !== 14'h100 || cnt !== 3'd1) begin failures++; $display("FAIL call got=%0h/%0d exp=100/1", pc, cnt); end
    ret = 1; step(); idle();
    checks++; if (pc !== 14'd11 || cnt !== 3'd0) begin failures++; $display("FAIL ret got=%0h/%0d exp=b/0", pc, cnt); end
    stall = 1; branch = 1; baddr = 14'h2A; step(); idle();
    checks++; if (pc !== 14'h2A) begin failures++; $display("FAIL branch_stall got=%0h exp=2a", pc); end
    // Conflicting requests: the branch wins and nothing is pushed or popped.
    branch = 1; call = 1; ret = 1; baddr = 14'h50; step(); idle();
    checks++; if (pc !== 14'h50 || cnt !== 3'd0 || unf !== 1'b0) begin failures++; $display("FAIL conflict_bcr got=%0h/%0d/%b exp=50/0/0", pc, cnt, unf); end
    call = 1; ret = 1; baddr = 14'h60; step(); idle();
    checks++; if (pc !== 14'h60 || cnt !== 3'd1) begin failures++; $display("FAIL conflict_cr got=%0h/%0d exp=60/1", pc, cnt); end
    #3 rst_n = 0;
    #1;
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d exp=0", cnt); end
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_overflow_underflow();
    logic [13:0] exp_pc;
    do_reset();
    branch = 1; baddr = 14'd1; step(); idle();
    for (int p = 1; p <= 5; p++) begin
      call = 1; baddr = (p == 5) ? 14'h300 : 14'(p + 1); step(); idle();
      checks++; if (cnt !== 3'((p > 4) ? 4 : p)) begin failures++; $display("FAIL nest_cnt got=%0d exp=%0d", cnt, (p > 4) ? 4 : p); end
      checks++; if (ovf !== (p == 5)) begin failures++; $display("FAIL nest_ovf got=%b exp=%b", ovf, (p == 5)); end
    end
    for (int r = 0; r < 4; r++) begin
      ret = 1; step(); idle();
      exp_pc = 14'(6 - r);
      checks++; if (pc !== exp_pc || cnt !== 3'(3 - r)) begin failures++; $display("FAIL unwind got=%0h/%0d exp=%0h/%0d", pc, cnt, exp_pc, 3 - r); end
    end
    ret = 1; step(); idle();
    checks++; if (pc !== 14'd4 || cnt !== 3'd0 || unf !== 1'b1) begin failures++; $display("FAIL underflow got=%0h/%0d/%b exp=4/0/1", pc, cnt, unf); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    step();
    checks++; if (unf !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", unf); end
  endtask

  task automatic test_wrap();
    do_reset();
    branch = 1; baddr = 14'h3FFF; step(); idle();
    step();
    checks++; if (pc !== 14'h0) begin failures++; $display("FAIL wrap14 got=%0h exp=0", pc); end
    step();
    checks++; if (pc2 !== 8'hFC) begin failures++; $display("FAIL step4_pre got=%0h exp=fc", pc2); end
    step();
    checks++; if (pc2 !== 8'h00) begin failures++; $display("FAIL wrap8 got=%0h exp=0", pc2); end
  endtask

`ifdef CEESPU_PC_IRQ_EN
  task automatic test_irq();
    do_reset();
    branch = 1; baddr = 14'h20; step(); idle();
    irq = 1; step();
    checks++; if (pc !== 14'h4 || epc !== 14'h20 || in_irq !== 1'b1) begin failures++; $display("FAIL irq_take got=%0h/%0h/%b exp=4/20/1", pc, epc, in_irq); end
    step();
    checks++; if (pc !== 14'h5 || epc !== 14'h20) begin failures++; $display("FAIL irq_no_reentry got=%0h/%0h exp=5/20", pc, epc); end
    irq = 0; reti = 1; step(); idle();
    checks++; if (pc !== 14'h20 || in_irq !== 1'b0) begin failures++; $display("FAIL reti got=%0h/%b exp=20/0", pc, in_irq); end
    irq = 1; branch = 1; baddr = 14'h40; step(); branch = 0;
    checks++; if (pc !== 14'h40 || in_irq !== 1'b0) begin failures++; $display("FAIL irq_blocked got=%0h/%b exp=40/0", pc, in_irq); end
    step(); irq = 0;
    checks++; if (pc !== 14'h4 || epc !== 14'h40 || in_irq !== 1'b1) begin failures++; $display("FAIL irq_late got=%0h/%0h/%b exp=4/40/1", pc, epc, in_irq); end
    stall = 1; reti = 1; step(); idle();
    checks++; if (pc !== 14'h40 || in_irq !== 1'b0) begin failures++; $display("FAIL reti_stall got=%0h/%b exp=40/0", pc, in_irq); end
    stall = 1; reti = 1; step(); idle();
    checks++; if (pc !== 14'h41 || in_irq !== 1'b0) begin failures++; $display("FAIL stray_reti got=%0h/%b exp=41/0", pc, in_irq); end
    stall = 1; irq = 1; step(); stall = 0;
    checks++; if (pc !== 14'h41 || in_irq !== 1'b0) begin failures++; $display("FAIL irq_stall got=%0h/%b exp=41/0", pc, in_irq); end
    step(); idle();
    checks++; if (pc !== 14'h4 || epc !== 14'h41 || cnt !== 3'd0) begin failures++; $display("FAIL irq_after_stall got=%0h/%0h/%0d exp=4/41/0", pc, epc, cnt); end
  endtask
`else
  task automatic test_irq_ignored();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      irq = i[0]; reti = ~i[0]; step();
      checks++; if (pc !== 14'(i) || in_irq !== 1'b0 || epc !== 14'h0) begin failures++; $display("FAIL irq_ignored got=%0h/%b/%0h exp=%0h/0/0", pc, in_irq, epc, i); end
    end
    stall = 1; reti = 1; step(); idle();
    checks++; if (pc !== 14'd6) begin failures++; $display("FAIL reti_ignored got=%0h exp=6", pc); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      branch = ($urandom_range(0, 9) == 0);
      call   = ($urandom_range(0, 3) == 0);
      ret    = ($urandom_range(0, 3) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      irq    = ($urandom_range(0, 4) == 0);
      reti   = ($urandom_range(0, 9) == 0);
      baddr  = 14'($urandom);
      model_apply();
      step();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_pc n=%0d got=%0h exp=%0h", n, pc, m_pc); end
      checks++; if (cnt !== 3'(m_q.size())) begin failures++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, cnt, m_q.size()); end
      checks++; if (ovf !== m_ovf || unf !== m_unf) begin failures++; $display("FAIL rand_flags n=%0d got=%b%b exp=%b%b", n, ovf, unf, m_ovf, m_unf); end
      checks++; if (in_irq !== m_in || epc !== m_epc) begin failures++; $display("FAIL rand_irq n=%0d got=%b/%0h exp=%b/%0h", n, in_irq, epc, m_in, m_epc); end
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_call_ret();
    test_overflow_underflow();
    test_wrap();
`ifdef CEESPU_PC_IRQ_EN
    test_irq();
`else
    test_irq_ignored();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ceespu_pc_ras.md
Name: ceespu_pc_ras

Overview:
- Parametrised next-generation program counter for the ceespu fetch stage.
- Adds configurable address width, reset vector, increment step, and call/return redirection through a hardware return-address stack (RAS).
- Optional interrupt entry/exit with a saved exception PC.
- Drives the instruction-memory address each cycle; all redirects arrive from the execute/branch logic.

Parameters:
- ADDR_W, 14: width of PC, branch target and stack entries.
- STEP, 1: PC increment per sequential fetch (word addressing); applied modulo 2^ADDR_W.
- RESET_VECTOR, 0: O_PC value at reset.
- RAS_DEPTH, 4: number of return-address entries, >=2.
- IRQ_VECTOR, 14'h0004: handler entry address (used only with CEESPU_PC_IRQ_EN).

Ports:
- I_clk  in  1  clock, rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_stall  in  1  hold PC when no redirect is present.
- I_branch  in  1  jump to I_branchAddress.
- I_call  in  1  push O_PC+STEP onto the RAS, jump to I_branchAddress.
- I_ret  in  1  pop the RAS into the PC.
- I_branchAddress  in  ADDR_W  branch/call target.
- I_irq  in  1  level interrupt request (IRQ build only).
- I_reti  in  1  return from interrupt (IRQ build only).
- O_PC  out  ADDR_W  current fetch address.
- O_ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- O_ras_overflow  out  1  sticky; a push occurred while the RAS was full.
- O_ras_underflow  out  1  sticky; a pop occurred while the RAS was empty.
- O_in_irq  out  1  handler active (tied 0 without IRQ build).
- O_epc  out  ADDR_W  saved exception PC (tied 0 without IRQ build).

Behaviour:
- Reset (async assert, sync release):
  - O_PC=RESET_VECTOR.
  - O_ras_count=0; both sticky flags 0.
  - O_in_irq=0; O_epc=0.
  - Stack RAM contents are don't-care.
- All state updates on the rising edge of I_clk. Next PC is visible on O_PC one cycle after the request.
- Priority per cycle, highest first:
  1. IRQ take.
  2. I_reti.
  3. I_branch.
  4. I_call.
  5. I_ret.
  6. I_stall (hold).
  7. Sequential, O_PC+STEP.
- Simultaneous branch/call/ret are a protocol error. The priority above still resolves them deterministically, and the losing requests have no side effect (no push/pop).
- Redirects (branch/call/ret/reti) override I_stall. A stalled-but-redirected cycle still loads the target.
- Arithmetic: all PC sums are truncated to ADDR_W bits. Wrap from max to 0 is legal and silent.
- RAS is circular, with a top pointer and a count:
  - Push when count<RAS_DEPTH: write entry, count+1.
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, set O_ras_overflow.
  - Pop when count>0: O_PC<=top entry, count-1.
  - Pop when empty: O_PC<=O_PC+STEP, count stays 0, set O_ras_underflow.
- Sticky flags clear only on reset.
- Reset asserted mid-sequence clears the count immediately; no partial push survives.

Optional Feature:
- Macro: CEESPU_PC_IRQ_EN.
- With the macro defined:
  - An IRQ is taken when I_irq=1, O_in_irq=0, I_stall=0, and none of branch/call/ret/reti is asserted.
  - On take: O_epc<=O_PC, O_PC<=IRQ_VECTOR, O_in_irq<=1. The RAS is untouched.
  - An IRQ blocked by a redirect or stall is taken on the first eligible cycle.
  - I_reti with O_in_irq=1: O_PC<=O_epc, O_in_irq<=0.
  - I_reti with O_in_irq=0: treated as O_PC+STEP, ignoring I_stall.
- Without the macro: I_irq and I_reti are ignored, O_in_irq=0, O_epc=0, and no EPC register is synthesised.

Test Plan:
- Reset then 5 cycles with no requests -> O_PC 0,1,2,3,4,5. Hold I_stall 3 cycles -> O_PC stays 5. Assert I_rst_n=0 async mid-cycle -> O_PC=0 immediately.
- O_PC=10, I_call target 0x100 -> O_PC=0x100, count=1. Next cycle I_ret -> O_PC=11, count=0. Branch with I_stall=1 -> target loaded.
- RAS_DEPTH=4: five nested calls from PCs 1..5 -> count=4, O_ras_overflow=1. Then five rets -> O_PC sequence 6,5,4,3, then 5th ret gives prior PC+1, O_ras_underflow=1.
- ADDR_W=14, O_PC=0x3FFF, sequential -> O_PC=0. STEP=4, ADDR_W=8 from 0xFC -> 0x00.
- IRQ build, O_PC=0x20, I_irq=1 -> O_PC=0x0004, O_epc=0x20, O_in_irq=1. I_irq held -> no re-entry. I_reti -> O_PC=0x20, O_in_irq=0.
- IRQ build: I_irq with I_branch same cycle -> branch taken first, IRQ next cycle with O_epc=branch target. Non-IRQ build: I_irq toggling -> O_PC unaffected.
